// File: rtl/stack_ops.sv
// stack_ops: Forth-style stack with the top of stack held in a register and
// the remaining cells in a flop array. Executes one manipulation opcode per
// clock. Illegal operations are suppressed and raise sticky error flags.
module stack_ops #(
  parameter int DSZ   = 32,
  parameter int DEPTH = 16,
  parameter int SSZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [3:0]     op,
  input  logic [DSZ-1:0] vi,
  input  logic [SSZ-1:0] n,
  input  logic           clr_err,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] s0,
  output logic [DSZ-1:0] s1,
  output logic [SSZ:0]   cnt,
  output logic           empty,
  output logic           full,
  output logic           err_ovf,
  output logic           err_udf
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_PUSH = 4'd1,
    OP_POP  = 4'd2,
    OP_LOAD = 4'd3,
    OP_DUP  = 4'd4,
    OP_SWAP = 4'd5,
    OP_OVER = 4'd6,
    OP_ROT  = 4'd7,
    OP_PICK = 4'd8
  } op_e;

  localparam logic [SSZ:0] C0        = (SSZ+1)'(0);
  localparam logic [SSZ:0] C1        = (SSZ+1)'(1);
  localparam logic [SSZ:0] C2        = (SSZ+1)'(2);
  localparam logic [SSZ:0] C3        = (SSZ+1)'(3);
  localparam logic [SSZ:0] CNT_FULL  = (SSZ+1)'(DEPTH);

  // Architectural state
  logic [DSZ-1:0] tos_q, tos_d;
  logic [SSZ:0]   cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic [DSZ-1:0] body_q [DEPTH-1];

  // Derived body indices (body[cnt-1] is the slot just below a new TOS)
  logic [SSZ-1:0] idx_m1_s, idx_m2_s, idx_m3_s, pick_idx_s;
  logic [DSZ-1:0] s0_s, s1_s, pick_val_s;
  logic           is_full_s;

  // Body write ports: port 0 is the general push slot, port 1 rewrites s0
  logic           wr0_en_s, wr1_en_s;
  logic [SSZ-1:0] wr0_idx_s;
  logic [DSZ-1:0] wr0_data_s;
  logic           set_ovf_s, set_udf_s;

  assign idx_m1_s   = SSZ'(cnt_q - C1);
  assign idx_m2_s   = SSZ'(cnt_q - C2);
  assign idx_m3_s   = SSZ'(cnt_q - C3);
  assign pick_idx_s = SSZ'(cnt_q - C1 - {1'b0, n});
  assign is_full_s  = (cnt_q == CNT_FULL);

  // Second and third cells read straight from the body, zero when absent
  always_comb begin
    s0_s = {DSZ{1'b0}};
    s1_s = {DSZ{1'b0}};
    if (cnt_q >= C2) begin
      s0_s = body_q[idx_m2_s];
    end else begin
      s0_s = {DSZ{1'b0}};
    end
    if (cnt_q >= C3) begin
      s1_s = body_q[idx_m3_s];
    end else begin
      s1_s = {DSZ{1'b0}};
    end
  end

  // Cell selected by PICK: index 0 is the TOS register itself
  always_comb begin
    pick_val_s = tos_q;
    if ((n == {SSZ{1'b0}}) || ({1'b0, n} >= cnt_q)) begin
      pick_val_s = tos_q;
    end else begin
      pick_val_s = body_q[pick_idx_s];
    end
  end

  // Opcode decode: precondition checks, next TOS/count and body writes
  always_comb begin
    tos_d      = tos_q;
    cnt_d      = cnt_q;
    wr0_en_s   = 1'b0;
    wr0_idx_s  = idx_m1_s;
    wr0_data_s = tos_q;
    wr1_en_s   = 1'b0;
    set_ovf_s  = 1'b0;
    set_udf_s  = 1'b0;
    if (en) begin
      case (op)
        OP_PUSH: begin
          if (is_full_s) begin
            set_ovf_s = 1'b1;
          end else begin
            tos_d    = vi;
            cnt_d    = cnt_q + C1;
            wr0_en_s = (cnt_q >= C1);
          end
        end
        OP_POP: begin
          if (cnt_q == C0) begin
            set_udf_s = 1'b1;
          end else begin
            tos_d = s0_s;
            cnt_d = cnt_q - C1;
          end
        end
        OP_LOAD: begin
          if (cnt_q == C0) begin
            set_udf_s = 1'b1;
          end else begin
            tos_d = vi;
          end
        end
        OP_DUP: begin
          if (cnt_q == C0) begin
            set_udf_s = 1'b1;
          end else if (is_full_s) begin
            set_ovf_s = 1'b1;
          end else begin
            wr0_en_s = 1'b1;
            cnt_d    = cnt_q + C1;
          end
        end
        OP_SWAP: begin
          if (cnt_q < C2) begin
            set_udf_s = 1'b1;
          end else begin
            tos_d    = s0_s;
            wr1_en_s = 1'b1;
          end
        end
        OP_OVER: begin
          if (cnt_q < C2) begin
            set_udf_s = 1'b1;
          end else if (is_full_s) begin
            set_ovf_s = 1'b1;
          end else begin
            wr0_en_s = 1'b1;
            tos_d    = s0_s;
            cnt_d    = cnt_q + C1;
          end
        end
        OP_ROT: begin
          if (cnt_q < C3) begin
            set_udf_s = 1'b1;
          end else begin
            // third cell comes up to TOS; old s0 sinks to s1, old TOS to s0
            tos_d      = s1_s;
            wr0_en_s   = 1'b1;
            wr0_idx_s  = idx_m3_s;
            wr0_data_s = s0_s;
            wr1_en_s   = 1'b1;
          end
        end
        OP_PICK: begin
          if ({1'b0, n} >= cnt_q) begin
            set_udf_s = 1'b1;
          end else if (is_full_s) begin
            set_ovf_s = 1'b1;
          end else begin
            wr0_en_s = 1'b1;
            tos_d    = pick_val_s;
            cnt_d    = cnt_q + C1;
          end
        end
        default: begin
          tos_d = tos_q;
        end
      endcase
    end else begin
      tos_d = tos_q;
    end
  end

  // Sticky error flags: a new violation beats a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (set_ovf_s) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (set_udf_s) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // TOS, depth and flag registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q <= {DSZ{1'b0}};
      cnt_q <= C0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Body array: not reset, only cells below the valid depth are ever read
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (wr0_en_s && (wr0_idx_s == SSZ'(i))) begin
        body_q[i] <= wr0_data_s;
      end
      if (wr1_en_s && (idx_m2_s == SSZ'(i))) begin
        body_q[i] <= tos_q;
      end
    end
  end

  assign tos     = tos_q;
  assign s0      = s0_s;
  assign s1      = s1_s;
  assign cnt     = cnt_q;
  assign empty   = (cnt_q == C0);
  assign full    = is_full_s;
  assign err_ovf = ovf_q;
  assign err_udf = udf_q;

endmodule

// File: tb/tb_stack_ops.sv
// tb_stack_ops: directed plan steps plus random op streams, each result
// compared against a queue-based model of the stack.
module tb_stack_ops;

  localparam int DSZ   = 32;
  localparam int DEPTH = 16;
  localparam int SSZ   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [3:0]     op = 4'd0;
  logic [DSZ-1:0] vi = 32'd0;
  logic [SSZ-1:0] n = 4'd0;
  logic           clr_err = 1'b0;
  logic [DSZ-1:0] tos, s0, s1;
  logic [SSZ:0]   cnt;
  logic           empty, full, err_ovf, err_udf;

  int passes = 0;
  int checks = 0;

  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;

  stack_ops #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .vi(vi), .n(n),
    .clr_err(clr_err), .tos(tos), .s0(s0), .s1(s1), .cnt(cnt),
    .empty(empty), .full(full), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int sz;
    logic [31:0] et, e0, e1;
    sz = mq.size();
    et = (sz >= 1) ? mq[sz-1] : 32'd0;
    e0 = (sz >= 2) ? mq[sz-2] : 32'd0;
    e1 = (sz >= 3) ? mq[sz-3] : 32'd0;
    chk({tag, ".tos"}, 64'(tos), 64'(et));
    chk({tag, ".s0"}, 64'(s0), 64'(e0));
    chk({tag, ".s1"}, 64'(s1), 64'(e1));
    chk({tag, ".cnt"}, 64'(cnt), 64'(sz));
    chk({tag, ".empty"}, 64'(empty), 64'(sz == 0));
    chk({tag, ".full"}, 64'(full), 64'(sz == DEPTH));
    chk({tag, ".ovf"}, 64'(err_ovf), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(err_udf), 64'(m_udf));
  endtask

  // Reference behaviour: the queue holds the stack, last element is the top
  task automatic model(input bit e, input int o, input logic [31:0] v, input int nn, input bit c);
    int sz;
    bit so, su;
    logic [31:0] t;
    sz = mq.size();
    so = 1'b0;
    su = 1'b0;
    if (e) begin
      case (o)
        1: if (sz == DEPTH) so = 1'b1; else mq.push_back(v);
        2: if (sz == 0) su = 1'b1; else void'(mq.pop_back());
        3: if (sz == 0) su = 1'b1; else mq[sz-1] = v;
        4: if (sz == 0) su = 1'b1; else if (sz == DEPTH) so = 1'b1; else mq.push_back(mq[sz-1]);
        5: if (sz < 2) su = 1'b1;
           else begin t = mq[sz-1]; mq[sz-1] = mq[sz-2]; mq[sz-2] = t; end
        6: if (sz < 2) su = 1'b1; else if (sz == DEPTH) so = 1'b1; else mq.push_back(mq[sz-2]);
        7: if (sz < 3) su = 1'b1;
           else begin t = mq[sz-3]; mq.delete(sz-3); mq.push_back(t); end
        8: if (nn >= sz) su = 1'b1; else if (sz == DEPTH) so = 1'b1; else mq.push_back(mq[sz-1-nn]);
        default: ;
      endcase
    end
    if (so) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (su) m_udf = 1'b1; else if (c) m_udf = 1'b0;
  endtask

  task automatic step(input string tag, input bit e, input int o, input logic [31:0] v,
                      input int nn, input bit c);
    en = e;
    op = 4'(o);
    vi = v;
    n = 4'(nn);
    clr_err = c;
    model(e, o, v, nn, c);
    @(posedge clk);
    #1;
    en = 1'b0;
    clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input int len, input int bias_op);
    int r;
    for (int k = 0; k < len; k++) begin
      r = $urandom_range(0, 19);
      step("rand", ($urandom_range(0, 7) != 0), (r >= 16) ? bias_op : r, $urandom,
           $urandom_range(0, DEPTH - 1), ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // fill and overflow
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 1, 32'(1000 + i), 0, 1'b0);
    chk("fill_tos", 64'(tos), 64'd1015);
    chk("fill_s1", 64'(s1), 64'd1013);
    step("ovf_push", 1'b1, 1, 32'd2000, 0, 1'b0);
    chk("ovf_flag", 64'(err_ovf), 64'd1);

    // drain and underflow
    for (int i = 0; i < 16; i++) step("drain", 1'b1, 2, 32'd0, 0, 1'b0);
    chk("drain_tos", 64'(tos), 64'd0);
    step("udf_pop", 1'b1, 2, 32'd0, 0, 1'b0);
    step("udf_pop_clr", 1'b1, 2, 32'd0, 0, 1'b1);
    chk("set_beats_clr", 64'(err_udf), 64'd1);
    step("clr", 1'b1, 0, 32'd0, 0, 1'b1);
    chk("clr_udf", 64'(err_udf), 64'd0);

    // manipulation
    do_reset();
    step("p1", 1'b1, 1, 32'd1, 0, 1'b0);
    step("p2", 1'b1, 1, 32'd2, 0, 1'b0);
    step("p3", 1'b1, 1, 32'd3, 0, 1'b0);
    step("rot", 1'b1, 7, 32'd0, 0, 1'b0);
    chk("rot_tos", 64'(tos), 64'd1);
    step("swap", 1'b1, 5, 32'd0, 0, 1'b0);
    step("over", 1'b1, 6, 32'd0, 0, 1'b0);
    step("dup", 1'b1, 4, 32'd0, 0, 1'b0);
    step("load", 1'b1, 3, 32'd7, 0, 1'b0);
    chk("load_tos", 64'(tos), 64'd7);

    // pick
    do_reset();
    for (int i = 1; i <= 4; i++) step("pp", 1'b1, 1, 32'(10 * i), 0, 1'b0);
    step("pick3", 1'b1, 8, 32'd0, 3, 1'b0);
    chk("pick3_tos", 64'(tos), 64'd10);
    step("pick7", 1'b1, 8, 32'd0, 7, 1'b0);
    step("pick0", 1'b1, 8, 32'd0, 0, 1'b0);

    // underflow guards and en=0
    do_reset();
    step("one", 1'b1, 1, 32'd9, 0, 1'b0);
    step("g_swap", 1'b1, 5, 32'd0, 0, 1'b0);
    step("g_over", 1'b1, 6, 32'd0, 0, 1'b0);
    step("g_rot", 1'b1, 7, 32'd0, 0, 1'b0);
    step("clr_en0", 1'b0, 0, 32'd0, 0, 1'b1);
    step("en0_pop", 1'b0, 2, 32'd0, 0, 1'b0);
    step("rsv", 1'b1, 12, 32'd0, 0, 1'b0);

    // random streams biased to fill then to drain
    random_run(300, 1);
    random_run(300, 2);
    random_run(200, 8);

    // async reset mid-cycle at depth 5
    do_reset();
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1, 32'(50 + i), 0, 1'b0);
    en = 1'b1;
    op = 4'd1;
    vi = 32'd99;
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check_all("async_rst");
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    step("post_rst", 1'b1, 1, 32'd5, 0, 1'b0);
    chk("post_rst_tos", 64'(tos), 64'd5);

    random_run(200, 6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stack_ops.md
Name: stack_ops

Overview:
- Parametrised Forth stack with a TOS register cache and a flop-based body.
- Executes one stack-manipulation opcode per clock: PUSH, POP, LOAD, DUP, SWAP, OVER, ROT, PICK.
- Reports depth, full/empty status and sticky overflow/underflow errors.
- Serves as the data/return stack primitive for the eForth core; replaces the push/pop-only stack.

Parameters:
DSZ, 32, cell width in bits
DEPTH, 16, total capacity in cells including TOS (power of 2, >=4)
SSZ, $clog2(DEPTH), index width; depth count is SSZ+1 bits

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  op qualifier; 0 = hold all state
op  in  4  opcode (see Behaviour)
vi  in  DSZ  input cell for PUSH/LOAD
n  in  SSZ  PICK index (0 = TOS)
clr_err  in  1  synchronous clear of sticky error flags
tos  out  DSZ  top of stack (registered)
s0  out  DSZ  second cell (combinational from state)
s1  out  DSZ  third cell (combinational from state)
cnt  out  SSZ+1  number of valid cells, 0..DEPTH
empty  out  1  cnt==0
full  out  1  cnt==DEPTH
err_ovf  out  1  sticky overflow
err_udf  out  1  sticky underflow

Behaviour:
- Reset (async, any time, including mid-op):
  - cnt=0, tos=0, err_ovf=0, err_udf=0; body memory is not reset.
  - Operation resumes on the first rising edge after rst deasserts.
- Timing: op/vi/n are sampled at a rising edge with en=1; tos, cnt and flags update on that edge.
- s0/s1 reflect the new state in the same cycle.
  - s0=0 when cnt<2; s1=0 when cnt<3.
  - tos=0 whenever cnt==0, including after POP from cnt==1.
- Body: array of DEPTH-1 cells; s0=body[cnt-2], s1=body[cnt-3].
- Opcodes (required cnt precondition; effect):
  - 0 NOP: none.
  - 1 PUSH (cnt<DEPTH): body<=tos if cnt>=1; tos<=vi; cnt+1.
  - 2 POP (cnt>=1): tos<=s0 (or 0 if cnt==1); cnt-1.
  - 3 LOAD (cnt>=1): tos<=vi; cnt unchanged.
  - 4 DUP (1<=cnt<DEPTH): body<=tos; cnt+1.
  - 5 SWAP (cnt>=2): tos<=s0, s0<=tos.
  - 6 OVER (2<=cnt<DEPTH): body<=tos; tos<=old s0; cnt+1.
  - 7 ROT (cnt>=3): (s1,s0,tos) -> (s0,tos,s1).
  - 8 PICK (n<cnt, cnt<DEPTH): push copy of cell n, where n=0 is tos, 1 is s0, etc.; cnt+1.
  - 9-15 reserved: treated as NOP, no error.
- Precondition violation:
  - op suppressed; tos/cnt/body unchanged.
  - Growth past DEPTH sets err_ovf; missing operands set err_udf.
  - PICK with n>=cnt sets err_udf; PICK when full sets err_ovf.
  - If both apply, err_udf takes priority.
- Sticky flags:
  - Set in the cycle of the violation; hold until rst or clr_err=1.
  - clr_err with a simultaneous violation: the set wins.
- en=0: op ignored; no error raised; clr_err still honoured.
- No wrap-around: cnt saturates within 0..DEPTH by suppression.

Test Plan:
- Fill and overflow: reset, then PUSH 1000..1015 (16 ops) -> cnt=16, full=1, tos=1015, s0=1014, s1=1013. 17th PUSH 2000 -> err_ovf=1, tos=1015, cnt=16.
- Drain and underflow: POP x16 from full -> tos steps 1014..1000 then 0; cnt=0, empty=1. Further POP -> err_udf=1, cnt=0. clr_err -> err_udf=0.
- Manipulation: PUSH 1,2,3; ROT -> tos=1,s0=3,s1=2. SWAP -> tos=3,s0=1. OVER -> tos=1,cnt=4. DUP -> tos=1,s0=1,cnt=5. LOAD 7 -> tos=7,cnt=5.
- PICK: PUSH 10,20,30,40; PICK n=3 -> tos=10,cnt=5. PICK n=7 -> err_udf=1, state unchanged.
- Underflow guards: cnt=1, issue SWAP/OVER/ROT each -> err_udf=1, tos unchanged. en=0 with POP -> no change, no error.
- Async reset: assert rst mid-cycle between edges during a PUSH sequence at cnt=5 -> tos=0, cnt=0, flags=0 immediately, before the next edge. After release, PUSH 5 -> tos=5, cnt=1.
